// File: rtl/id_ex_stage.sv
// ID stage decode, load-use hazard detection and the ID/EX pipeline register.
// Hazards stall for one cycle; a branch flush squashes the incoming instruction.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ifid_instr,
    input  logic [31:0]      ifid_pc4,
    input  logic [31:0]      read_data1,
    input  logic [31:0]      read_data2,
    input  logic             flush,
    output logic [4:0]       read_register1,
    output logic [4:0]       read_register2,
    output logic             pcwrite,
    output logic             ifid_write,
    output logic             ex_valid,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_dest,
    output logic [31:0]      ex_op1,
    output logic [31:0]      ex_op2,
    output logic [31:0]      ex_imm,
    output logic [31:0]      ex_pc4,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_alusrc,
    output logic             ex_branch,
    output logic             ex_illegal,
    output logic [3:0]       ex_aluop,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       branch;
        logic       illegal;
        logic [3:0] aluop;
        logic [4:0] dest;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[31:26])
            6'h00: begin
                // The all-zero word is a nop and keeps every control bit low.
                if (instr != 32'h0000_0000) begin
                    c.regwrite = 1'b1;
                    c.dest     = instr[15:11];
                    case (instr[5:0])
                        6'h20:   c.aluop = ALU_ADD;
                        6'h22:   c.aluop = ALU_SUB;
                        6'h24:   c.aluop = ALU_AND;
                        6'h25:   c.aluop = ALU_OR;
                        6'h2A:   c.aluop = ALU_SLT;
                        default: begin
                            c         = '0;
                            c.illegal = 1'b1;
                        end
                    endcase
                end else begin
                    c = '0;
                end
            end
            6'h08: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.dest     = instr[20:16];
            end
            6'h23: begin
                c.regwrite = 1'b1;
                c.memread  = 1'b1;
                c.alusrc   = 1'b1;
                c.dest     = instr[20:16];
            end
            6'h2B: begin
                c.memwrite = 1'b1;
                c.alusrc   = 1'b1;
            end
            6'h04: begin
                c.branch = 1'b1;
                c.aluop  = ALU_SUB;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    ctrl_t dec_s;
    logic  uses_rt_s;
    logic  hazard_s;
    logic  stall_s;

    assign read_register1 = ifid_instr[25:21];
    assign read_register2 = ifid_instr[20:16];

    // Decode the ID instruction.
    always_comb begin
        dec_s = decode(ifid_instr);
    end

    // Load-use hazard detection and PC / IF/ID write enables.
    always_comb begin
        uses_rt_s = 1'b0;
        hazard_s  = 1'b0;
        case (ifid_instr[31:26])
            6'h00, 6'h2B, 6'h04: uses_rt_s = 1'b1;
            default:             uses_rt_s = 1'b0;
        endcase
        if (ex_valid && ex_memread && (ex_rt != 5'd0)) begin
            if (ex_rt == ifid_instr[25:21]) begin
                hazard_s = 1'b1;
            end else if (uses_rt_s && (ex_rt == ifid_instr[20:16])) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = 1'b0;
            end
        end else begin
            hazard_s = 1'b0;
        end
        // Flush wins over a hazard: the dependent instruction is squashed anyway.
        stall_s    = hazard_s && !flush;
        pcwrite    = !stall_s;
        ifid_write = !stall_s;
    end

    // ID/EX register: bubble on reset, flush or stall, otherwise the decoded instruction.
    always_ff @(posedge clk) begin
        if (rst || flush || stall_s) begin
            ex_valid    <= 1'b0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_dest     <= 5'd0;
            ex_op1      <= 32'h0000_0000;
            ex_op2      <= 32'h0000_0000;
            ex_imm      <= 32'h0000_0000;
            ex_pc4      <= 32'h0000_0000;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_branch   <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_aluop    <= 4'd0;
        end else begin
            ex_valid    <= 1'b1;
            ex_rs       <= ifid_instr[25:21];
            ex_rt       <= ifid_instr[20:16];
            ex_dest     <= dec_s.dest;
            ex_op1      <= read_data1;
            ex_op2      <= read_data2;
            ex_imm      <= {{16{ifid_instr[15]}}, ifid_instr[15:0]};
            ex_pc4      <= ifid_pc4;
            ex_regwrite <= dec_s.regwrite;
            ex_memread  <= dec_s.memread;
            ex_memwrite <= dec_s.memwrite;
            ex_alusrc   <= dec_s.alusrc;
            ex_branch   <= dec_s.branch;
            ex_illegal  <= dec_s.illegal;
            ex_aluop    <= dec_s.aluop;
        end
    end

    // Saturating load-use stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_s && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_ONE;
        end else begin
            stall_count <= stall_count;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: cycle table with a scoreboard of expected
// ID/EX contents, plus a reset check and a counter saturation sequence.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush;
    logic [31:0] ifid_instr, ifid_pc4, read_data1, read_data2;
    logic [4:0]  read_register1, read_register2, ex_rs, ex_rt, ex_dest;
    logic        pcwrite, ifid_write, ex_valid;
    logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc4;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_branch, ex_illegal;
    logic [3:0]  ex_aluop;
    logic [15:0] stall_count;

    logic [4:0]  s_rr1, s_rr2, s_rs, s_rt, s_dest;
    logic        s_pcw, s_ifw, s_valid;
    logic [31:0] s_op1, s_op2, s_imm, s_pc4;
    logic        s_rw, s_mr, s_mw, s_as, s_br, s_il;
    logic [3:0]  s_aluop;
    logic [1:0]  s_cnt;

    id_ex_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
        .read_data1(read_data1), .read_data2(read_data2), .flush(flush),
        .read_register1(read_register1), .read_register2(read_register2),
        .pcwrite(pcwrite), .ifid_write(ifid_write), .ex_valid(ex_valid),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_illegal(ex_illegal),
        .ex_aluop(ex_aluop), .stall_count(stall_count)
    );

    // Narrow counter copy so saturation is reachable in a few cycles.
    id_ex_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
        .read_data1(read_data1), .read_data2(read_data2), .flush(flush),
        .read_register1(s_rr1), .read_register2(s_rr2),
        .pcwrite(s_pcw), .ifid_write(s_ifw), .ex_valid(s_valid),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_dest(s_dest),
        .ex_op1(s_op1), .ex_op2(s_op2), .ex_imm(s_imm), .ex_pc4(s_pc4),
        .ex_regwrite(s_rw), .ex_memread(s_mr), .ex_memwrite(s_mw),
        .ex_alusrc(s_as), .ex_branch(s_br), .ex_illegal(s_il),
        .ex_aluop(s_aluop), .stall_count(s_cnt)
    );

    // ctl order: {regwrite, memread, memwrite, alusrc, branch, illegal}
    localparam logic [5:0] C_R = 6'b100000, C_ADDI = 6'b100100, C_LW = 6'b110100;
    localparam logic [5:0] C_SW = 6'b001100, C_BEQ = 6'b000010, C_ILL = 6'b000001;
    localparam logic [5:0] C_NO = 6'b000000;

    localparam logic [31:0] I_LW   = 32'h8D28_0000;  // lw   $8,0($9)
    localparam logic [31:0] I_ADD  = 32'h010B_5020;  // add  $10,$8,$11
    localparam logic [31:0] I_ADDI = 32'h212A_0005;  // addi $10,$9,5
    localparam logic [31:0] I_LW0  = 32'h8D20_0000;  // lw   $0,0($9)
    localparam logic [31:0] I_ADD0 = 32'h0000_5020;  // add  $10,$0,$0
    localparam logic [31:0] I_SW   = 32'hAD28_FFFC;  // sw   $8,-4($9)
    localparam logic [31:0] I_AI8S = 32'h210A_0005;  // addi $10,$8,5
    localparam logic [31:0] I_AI8D = 32'h2128_0007;  // addi $8,$9,7

    typedef struct {
        logic        rst;
        logic        flush;
        logic [31:0] instr;
        logic        pcw;
        logic        valid;
        logic [5:0]  ctl;
        logic [3:0]  aluop;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [5:0]  ctl;
        logic [3:0]  aluop;
        logic [4:0]  dest, rs, rt;
        logic [31:0] op1, op2, imm, pc4;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t v(logic r, logic f, logic [31:0] i, logic p, logic val,
                               logic [5:0] c, logic [3:0] a, logic [4:0] d,
                               logic [31:0] imm, logic [15:0] cnt);
        vec_t t;
        t.rst = r; t.flush = f; t.instr = i; t.pcw = p; t.valid = val;
        t.ctl = c; t.aluop = a; t.dest = d; t.imm = imm; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, n_vec, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic [31:0] instr);
        @(negedge clk);
        rst = r; flush = 1'b0; ifid_instr = instr;
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        vec_t t;
        rst = 1'b1; flush = 1'b0; ifid_instr = 32'h0; ifid_pc4 = 32'h0;
        read_data1 = 32'h0; read_data2 = 32'h0;

        //      rst   flush instr                pcw   valid ctl     alu   dest   imm            cnt
        tbl.push_back(v(1'b0, 1'b0, I_LW,          1'b1, 1'b1, C_LW,   4'd0, 5'd8,  32'h0,         16'd0));
        tbl.push_back(v(1'b0, 1'b0, I_ADD,         1'b0, 1'b0, C_NO,   4'd0, 5'd0,  32'h0,         16'd1));
        tbl.push_back(v(1'b0, 1'b0, I_ADD,         1'b1, 1'b1, C_R,    4'd0, 5'd10, 32'h5020,      16'd1));
        tbl.push_back(v(1'b0, 1'b0, I_LW,          1'b1, 1'b1, C_LW,   4'd0, 5'd8,  32'h0,         16'd1));
        tbl.push_back(v(1'b0, 1'b0, I_ADDI,        1'b1, 1'b1, C_ADDI, 4'd0, 5'd10, 32'h5,         16'd1));
        tbl.push_back(v(1'b0, 1'b0, I_LW0,         1'b1, 1'b1, C_LW,   4'd0, 5'd0,  32'h0,         16'd1));
        tbl.push_back(v(1'b0, 1'b0, I_ADD0,        1'b1, 1'b1, C_R,    4'd0, 5'd10, 32'h5020,      16'd1));
        tbl.push_back(v(1'b0, 1'b0, I_LW,          1'b1, 1'b1, C_LW,   4'd0, 5'd8,  32'h0,         16'd1));
        tbl.push_back(v(1'b0, 1'b1, I_ADD,         1'b1, 1'b0, C_NO,   4'd0, 5'd0,  32'h0,         16'd1));
        tbl.push_back(v(1'b0, 1'b0, 32'h0022_1822, 1'b1, 1'b1, C_R,    4'd1, 5'd3,  32'h1822,      16'd1));
        tbl.push_back(v(1'b0, 1'b0, 32'h00A6_2024, 1'b1, 1'b1, C_R,    4'd2, 5'd4,  32'h2024,      16'd1));
        tbl.push_back(v(1'b0, 1'b0, 32'h0022_3825, 1'b1, 1'b1, C_R,    4'd3, 5'd7,  32'h3825,      16'd1));
        tbl.push_back(v(1'b0, 1'b0, 32'h0022_482A, 1'b1, 1'b1, C_R,    4'd4, 5'd9,  32'h482A,      16'd1));
        tbl.push_back(v(1'b0, 1'b0, I_SW,          1'b1, 1'b1, C_SW,   4'd0, 5'd0,  32'hFFFF_FFFC, 16'd1));
        tbl.push_back(v(1'b0, 1'b0, 32'h1022_FFFF, 1'b1, 1'b1, C_BEQ,  4'd1, 5'd0,  32'hFFFF_FFFF, 16'd1));
        tbl.push_back(v(1'b0, 1'b0, 32'hFC00_0000, 1'b1, 1'b1, C_ILL,  4'd0, 5'd0,  32'h0,         16'd1));
        tbl.push_back(v(1'b0, 1'b0, 32'h0022_1801, 1'b1, 1'b1, C_ILL,  4'd0, 5'd0,  32'h1801,      16'd1));
        tbl.push_back(v(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, C_NO,   4'd0, 5'd0,  32'h0,         16'd1));
        tbl.push_back(v(1'b0, 1'b0, I_LW,          1'b1, 1'b1, C_LW,   4'd0, 5'd8,  32'h0,         16'd1));
        tbl.push_back(v(1'b0, 1'b0, I_SW,          1'b0, 1'b0, C_NO,   4'd0, 5'd0,  32'h0,         16'd2));
        tbl.push_back(v(1'b0, 1'b0, I_SW,          1'b1, 1'b1, C_SW,   4'd0, 5'd0,  32'hFFFF_FFFC, 16'd2));
        tbl.push_back(v(1'b0, 1'b0, I_LW,          1'b1, 1'b1, C_LW,   4'd0, 5'd8,  32'h0,         16'd2));
        tbl.push_back(v(1'b0, 1'b0, I_AI8S,        1'b0, 1'b0, C_NO,   4'd0, 5'd0,  32'h0,         16'd3));
        tbl.push_back(v(1'b0, 1'b0, I_AI8S,        1'b1, 1'b1, C_ADDI, 4'd0, 5'd10, 32'h5,         16'd3));
        tbl.push_back(v(1'b0, 1'b0, I_LW,          1'b1, 1'b1, C_LW,   4'd0, 5'd8,  32'h0,         16'd3));
        tbl.push_back(v(1'b0, 1'b0, I_AI8D,        1'b1, 1'b1, C_ADDI, 4'd0, 5'd8,  32'h7,         16'd3));
        tbl.push_back(v(1'b0, 1'b0, I_LW,          1'b1, 1'b1, C_LW,   4'd0, 5'd8,  32'h0,         16'd3));
        tbl.push_back(v(1'b1, 1'b0, I_ADD,         1'b0, 1'b0, C_NO,   4'd0, 5'd0,  32'h0,         16'd0));
        tbl.push_back(v(1'b0, 1'b0, I_ADD,         1'b1, 1'b1, C_R,    4'd0, 5'd10, 32'h5020,      16'd0));

        // Reset, then the first cycle after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #4;
        n_vec++;
        chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset stall_count", {16'd0, stall_count}, 32'd0);
        chk("post-reset pcwrite", {30'd0, pcwrite, ifid_write}, 32'd3);

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            @(negedge clk);
            rst = t.rst; flush = t.flush; ifid_instr = t.instr;
            ifid_pc4   = 32'h0040_0000 + 32'(i * 4);
            read_data1 = 32'hA000_0000 + 32'(i);
            read_data2 = 32'hB000_0000 + 32'(i * 16);
            e.valid = t.valid; e.ctl = t.ctl; e.aluop = t.aluop; e.dest = t.dest;
            e.imm = t.imm; e.cnt = t.cnt;
            e.rs  = t.valid ? t.instr[25:21] : 5'd0;
            e.rt  = t.valid ? t.instr[20:16] : 5'd0;
            e.op1 = t.valid ? read_data1 : 32'h0;
            e.op2 = t.valid ? read_data2 : 32'h0;
            e.pc4 = t.valid ? ifid_pc4 : 32'h0;
            sb.push_back(e);
            #4;
            n_vec++;
            chk("read_register1", {27'd0, read_register1}, {27'd0, t.instr[25:21]});
            chk("read_register2", {27'd0, read_register2}, {27'd0, t.instr[20:16]});
            chk("pcwrite", {31'd0, pcwrite}, {31'd0, t.pcw});
            chk("ifid_write", {31'd0, ifid_write}, {31'd0, t.pcw});
            @(posedge clk); #1;
            e = sb.pop_front();
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
            chk("ex_ctl", {26'd0, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_branch,
                ex_illegal}, {26'd0, e.ctl});
            chk("ex_aluop", {28'd0, ex_aluop}, {28'd0, e.aluop});
            if (!e.valid || e.ctl[5])
                chk("ex_dest", {27'd0, ex_dest}, {27'd0, e.dest});
            chk("ex_rs", {27'd0, ex_rs}, {27'd0, e.rs});
            chk("ex_rt", {27'd0, ex_rt}, {27'd0, e.rt});
            chk("ex_op1", ex_op1, e.op1);
            chk("ex_op2", ex_op2, e.op2);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_pc4", ex_pc4, e.pc4);
            chk("stall_count", {16'd0, stall_count}, {16'd0, e.cnt});
        end
        n_vec++;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        // Saturation: five load-use stalls; the 2-bit counter must stop at 3.
        cycle(1'b1, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b0, I_LW);
            cycle(1'b0, I_ADD);
            n_vec++;
            chk("sat stall_count", {30'd0, s_cnt}, (k > 3) ? 32'd3 : 32'(k));
            chk("wide stall_count", {16'd0, stall_count}, 32'(k));
            cycle(1'b0, I_ADD);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-002 SHALL have ports, in this order:
 - clk  in  1  single clock; all state updates on posedge clk.
 - rst  in  1  synchronous, active-high reset.
 - ifid_instr  in  32  instruction from the IF/ID register.
 - ifid_pc4  in  32  PC+4 of that instruction.
 - read_data1, read_data2  in  32 each  register-file read data.
 - flush  in  1  branch-taken squash from EX.
 - read_register1, read_register2  out  5 each  register-file read addresses.
 - pcwrite  out  1  PC update enable.
 - ifid_write  out  1  IF/ID update enable.
 - ex_valid  out  1  ID/EX holds a real instruction.
 - ex_rs, ex_rt, ex_dest  out  5 each  source and destination fields.
 - ex_op1, ex_op2, ex_imm, ex_pc4  out  32 each  operands, immediate, PC+4.
 - ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_branch, ex_illegal  out  1 each  control bits.
 - ex_aluop  out  4  ALU operation code.
 - stall_count  out  CNT_W  saturating count of load-use stalls.

Function
REQ-003 SHALL drive read_register1 = ifid_instr[25:21] and read_register2 = ifid_instr[20:16] combinationally.
REQ-004 SHALL decode opcode ifid_instr[31:26] in the ID stage as follows:
 - 0x00 R-type: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; dest = rd; regwrite = 1.
 - 0x08 addi: dest = rt, alusrc = 1, regwrite = 1.
 - 0x23 lw: dest = rt, alusrc = 1, memread = 1, regwrite = 1.
 - 0x2B sw: alusrc = 1, memwrite = 1.
 - 0x04 beq: branch = 1, aluop = sub.
REQ-005 SHALL use aluop encoding add=0, sub=1, and=2, or=3, slt=4.
REQ-006 SHALL treat the all-zero instruction as a nop: valid = 1, all control bits 0.
REQ-007 SHALL decode any other opcode or funct as illegal: illegal = 1, all other control bits 0, valid = 1.
REQ-008 SHALL form ex_imm as the sign extension of instr[15:0].
REQ-009 SHALL detect a load-use hazard, combinationally, when all of the following hold:
 - ex_valid and ex_memread are 1;
 - ex_rt != 0;
 - ex_rt equals the ID instruction's rs, or equals its rt when that instruction is R-type, sw or beq.
REQ-010 SHALL, on a load-use hazard with flush = 0, drive pcwrite = 0 and ifid_write = 0 in that cycle and load a bubble into ID/EX at the next posedge.
REQ-011 SHALL define a bubble as ex_valid = 0, all control bits 0, and all data fields 0.
REQ-012 SHALL keep each stall to exactly one cycle; the bubble clears ex_memread, so the hazard drops the following cycle.
REQ-013 SHALL, when flush = 1, load a bubble at the next posedge and drive pcwrite = 1 and ifid_write = 1.
REQ-014 SHALL give flush priority when flush and a hazard coincide: no stall, and stall_count is not incremented.
REQ-015 SHALL otherwise load the decoded ID instruction into ID/EX every posedge with 1-cycle latency:
 - ex_op1 = read_data1, ex_op2 = read_data2 (register-file values sampled at that posedge);
 - pcwrite = 1, ifid_write = 1.
REQ-016 SHALL increment stall_count by 1 on each stall cycle and saturate at all-ones without wrapping.
REQ-017 SHALL derive pcwrite and ifid_write only from current ID/EX state, flush and ifid_instr, with no registered delay.

Reset
REQ-018 SHALL, when rst = 1 at a posedge, set ID/EX to a bubble and stall_count to 0, overriding flush and any hazard.
REQ-019 SHALL drive pcwrite = 1 and ifid_write = 1 in the cycle after reset is released.
REQ-020 SHALL, when rst asserts mid-stall, clear the stall and leave no residual hazard.

Verification
REQ-021 lw $8,0($9) then add $10,$8,$11 -> the cycle add is in ID has pcwrite = 0 and ifid_write = 0; the next ex_valid = 0; add enters EX one cycle later; stall_count 0 -> 1.
REQ-022 lw $8 then addi $10,$9,5 (rt = 10) -> no stall, pcwrite stays 1.
REQ-023 lw $0,0($9) then add $10,$0,$0 -> no stall.
REQ-024 Load-use hazard with flush = 1 in the same cycle -> pcwrite = 1, bubble loaded, stall_count unchanged.
REQ-025 Preload stall_count = 0xFFFE, then three load-use stalls -> stall_count reads 0xFFFF and holds.
REQ-026 Opcode 0x3F -> ex_illegal = 1 and ex_valid = 1 the following cycle; rst = 1 during a stall -> ex_valid = 0, stall_count = 0, pcwrite = 1 afterwards.
